// File: rtl/mux_rr_sel_ctrl_pkg.sv
// Shared constants for the 4:1 mux select path.
// The controller and the mux both import these widths and state encodings.
package mux_rr_sel_ctrl_pkg;

    localparam int NUM_CH   = 4;
    localparam int SEL_W    = 2;
    localparam int MAX_HOLD = 15;
    localparam int HOLD_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/mux_rr_sel_ctrl_rr_pick4.sv
// rr_pick4: combinational round-robin picker for four requesters.
// Ports: req[3:0], last_ptr[1:0] in; any, win_idx[1:0], win_onehot[3:0] out.
module rr_pick4
    import mux_rr_sel_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last_ptr,
    output logic              any,
    output logic [SEL_W-1:0]  win_idx,
    output logic [NUM_CH-1:0] win_onehot
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Scan starts one past the last winner and wraps, so the
    // previous owner is the last candidate considered.
    always_comb begin
        any     = |req;
        win_idx = '0;
        idx     = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = last_ptr + SEL_W'(i + 1);
            if (!found && req[idx]) begin
                win_idx = idx;
                found   = 1'b1;
            end
        end
        win_onehot = any ? (NUM_CH'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/mux_rr_sel_ctrl.sv
// Round-robin select controller for the downstream 4:1 data mux.
// Ports: clk, rst_n, req[3:0], done[3:0] in; gnt[3:0], sel[1:0],
// sel_valid, busy, timeout out. Macro MUX_SEL_TIMEOUT_EN bounds
// ownership to MAX_HOLD cycles and pulses timeout on forced release.
module mux_rr_sel_ctrl
    import mux_rr_sel_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              sel_valid,
    output logic              busy,
    output logic              timeout
);

    logic [1:0]        state;
    logic [SEL_W-1:0]  last_ptr;
    logic              any;
    logic [SEL_W-1:0]  win_idx;
    logic [NUM_CH-1:0] win_onehot;
    logic              owner_done;
    logic              owner_gone;
    logic              force_rel;
    logic              release_own;

    rr_pick4 u_pick (
        .req        (req),
        .last_ptr   (last_ptr),
        .any        (any),
        .win_idx    (win_idx),
        .win_onehot (win_onehot)
    );

    // Only the current owner's bits matter while in OWN.
    assign owner_done  = done[sel];
    assign owner_gone  = !req[sel];
    assign release_own = owner_done | owner_gone | force_rel;

`ifdef MUX_SEL_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt;

    // Counter sits at 0 outside OWN, so the first OWN cycle sees 0.
    assign force_rel = (hold_cnt == HOLD_W'(MAX_HOLD - 1))
                     && !owner_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state == ST_OWN) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
            timeout <= (state == ST_OWN) && force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            sel      <= '0;
            last_ptr <= SEL_W'(NUM_CH - 1);
        end else begin
            unique case (state)
                ST_IDLE, ST_GAP: begin
                    // sel is left alone when idling so the mux
                    // input does not change needlessly.
                    if (any) begin
                        state    <= ST_OWN;
                        gnt      <= win_onehot;
                        sel      <= win_idx;
                        last_ptr <= win_idx;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (release_own) begin
                        state <= ST_GAP;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign sel_valid = (state == ST_OWN);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mux_rr_sel_ctrl.sv
// Directed self-checking bench for mux_rr_sel_ctrl.
// Each task drives one scenario and checks outputs inline.
module tb_mux_rr_sel_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    mux_rr_sel_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 4'b0000;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req   = 4'b1111;
        done  = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, sel, sel_valid, busy, timeout} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b sel=%0d sv=%b busy=%b to=%b exp all 0",
                     gnt, sel, sel_valid, busy, timeout);
        end
        req = 4'b0000;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req = 4'b0100;
        step();
        checks++;
        if ({gnt, sel, sel_valid, busy} !== {4'b0100, 2'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL single_own: got gnt=%b sel=%0d sv=%b busy=%b exp 0100 2 1 1",
                     gnt, sel, sel_valid, busy);
        end
        req  = 4'b0000;
        done = 4'b0100;
        step();
        checks++;
        if ({gnt, sel, sel_valid, busy} !== {4'b0000, 2'd2, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL single_gap: got gnt=%b sel=%0d sv=%b busy=%b exp 0000 2 0 1",
                     gnt, sel, sel_valid, busy);
        end
        done = 4'b0000;
        step();
        checks++;
        if ({gnt, sel, sel_valid, busy} !== {4'b0000, 2'd2, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_idle: got gnt=%b sel=%0d sv=%b busy=%b exp 0000 2 0 0",
                     gnt, sel, sel_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel;
        logic [3:0] exp_gnt;
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            exp_sel = 2'(k % 4);
            exp_gnt = 4'b0001 << exp_sel;
            checks++;
            if ({gnt, sel, sel_valid} !== {exp_gnt, exp_sel, 1'b1}) begin
                errors++;
                $display("FAIL rr_own%0d: got gnt=%b sel=%0d sv=%b exp %b %0d 1",
                         k, gnt, sel, sel_valid, exp_gnt, exp_sel);
            end
            step();
            checks++;
            if ({gnt, sel, sel_valid} !== {exp_gnt, exp_sel, 1'b1}) begin
                errors++;
                $display("FAIL rr_hold%0d: got gnt=%b sel=%0d sv=%b exp %b %0d 1",
                         k, gnt, sel, sel_valid, exp_gnt, exp_sel);
            end
            done = exp_gnt;
            step();
            checks++;
            if ({gnt, sel, sel_valid, busy} !== {4'b0000, exp_sel, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL rr_gap%0d: got gnt=%b sel=%0d sv=%b busy=%b exp 0000 %0d 0 1",
                         k, gnt, sel, sel_valid, busy, exp_sel);
            end
            done = 4'b0000;
            step();
        end
        req = 4'b0000;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle: got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_ignore();
        do_reset();
        req = 4'b0001;
        step();
        for (int k = 0; k < 6; k++) begin
            done = 4'b0010;
            req  = {k[0], 3'b001};
            step();
            checks++;
            if ({gnt, sel, sel_valid} !== {4'b0001, 2'd0, 1'b1}) begin
                errors++;
                $display("FAIL ignore%0d: got gnt=%b sel=%0d sv=%b exp 0001 0 1",
                         k, gnt, sel, sel_valid);
            end
        end
        done = 4'b0000;
        req  = 4'b0000;
        step();
        step();
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0010;
        step();
        checks++;
        if ({gnt, sel} !== {4'b0010, 2'd1}) begin
            errors++;
            $display("FAIL wd_own: got gnt=%b sel=%0d exp 0010 1", gnt, sel);
        end
        req = 4'b1000;
        step();
        checks++;
        if ({gnt, sel, sel_valid, busy} !== {4'b0000, 2'd1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wd_gap: got gnt=%b sel=%0d sv=%b busy=%b exp 0000 1 0 1",
                     gnt, sel, sel_valid, busy);
        end
        step();
        checks++;
        if ({gnt, sel, sel_valid} !== {4'b1000, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL wd_next: got gnt=%b sel=%0d sv=%b exp 1000 3 1",
                     gnt, sel, sel_valid);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_hold();
        int own_cycles;
        int to_seen;
        do_reset();
        req = 4'b1000;
        step();
`ifdef MUX_SEL_TIMEOUT_EN
        own_cycles = 0;
        to_seen    = 0;
        for (int k = 0; k < 40; k++) begin
            if (!sel_valid) break;
            own_cycles++;
            if (timeout) to_seen++;
            step();
        end
        checks++;
        if (own_cycles != 15) begin
            errors++;
            $display("FAIL hold_len: got %0d own cycles exp 15", own_cycles);
        end
        checks++;
        if ({timeout, gnt, to_seen[0]} !== {1'b1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL hold_timeout: got to=%b gnt=%b early=%0d exp 1 0000 0",
                     timeout, gnt, to_seen);
        end
        step();
        checks++;
        if ({timeout, sel_valid, gnt} !== {1'b0, 1'b1, 4'b1000}) begin
            errors++;
            $display("FAIL hold_regrant: got to=%b sv=%b gnt=%b exp 0 1 1000",
                     timeout, sel_valid, gnt);
        end
`else
        own_cycles = 1;
        to_seen    = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (sel_valid) own_cycles++;
            if (timeout) to_seen++;
        end
        checks++;
        if ({gnt, sel_valid} !== {4'b1000, 1'b1} || own_cycles != 101) begin
            errors++;
            $display("FAIL hold_unbounded: got gnt=%b sv=%b own=%0d exp 1000 1 101",
                     gnt, sel_valid, own_cycles);
        end
        checks++;
        if (to_seen != 0) begin
            errors++;
            $display("FAIL hold_no_timeout: got %0d pulses exp 0", to_seen);
        end
`endif
        req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0010;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, sel, sel_valid, busy, timeout} !== 9'b0) begin
            errors++;
            $display("FAIL midrst_clear: got gnt=%b sel=%0d sv=%b busy=%b to=%b exp all 0",
                     gnt, sel, sel_valid, busy, timeout);
        end
        #1;
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        checks++;
        if ({gnt, sel} !== {4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL midrst_ptr: got gnt=%b sel=%0d exp 0001 0", gnt, sel);
        end
        req = 4'b0000;
        step();
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 4'b0000;
        done  = 4'b0000;
        test_reset();
        test_single();
        test_round_robin();
        test_ignore();
        test_withdraw();
        test_hold();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
